// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event port carrying the granted channel index from the
// edge_event_arbiter (master) to a single event consumer (slave).
interface edge_event_arbiter_if #(
    parameter int CH_W = 2
);
    logic            evt_valid;
    logic [CH_W-1:0] evt_ch;
    logic            evt_ready;

    modport master (
        output evt_valid,
        output evt_ch,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        output evt_ready
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel Moore rising-edge detectors feeding sticky pending requests, shared
// round-robin onto one valid/ready event port. Define OVERRUN_FLAG_EN for ovr/ovr_clr.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_CH-1:0]     level,
    edge_event_arbiter_if.master evt,
    output logic                busy
`ifdef OVERRUN_FLAG_EN
    ,
    output logic [N_CH-1:0]     ovr,
    input  logic                ovr_clr
`endif
);

    typedef enum logic [1:0] {
        DET_ZERO = 2'b00,
        DET_EDGE = 2'b01,
        DET_ONE  = 2'b10
    } det_state_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    det_state_t      det_q [N_CH];
    det_state_t      det_d [N_CH];
    logic [N_CH-1:0] tick;

    arb_state_t      state_q, state_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [CH_W-1:0] last_q, last_d;
    logic [N_CH-1:0] grant_mask;

    logic            pick_found;
    logic [CH_W-1:0] pick_idx;

    // ------------------------------------------------------------------
    // Edge detectors
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
            det_d[i] = DET_ZERO;
            tick[i]  = (det_q[i] == DET_EDGE);
            case (det_q[i])
                DET_ZERO: det_d[i] = level[i] ? DET_EDGE : DET_ZERO;
                DET_EDGE: det_d[i] = level[i] ? DET_ONE  : DET_ZERO;
                DET_ONE:  det_d[i] = level[i] ? DET_ONE  : DET_ZERO;
                default:  det_d[i] = DET_ZERO;
            endcase
        end
    end

    // NOTE: async reset clears every state element here; there is no memory array to leave unreset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                det_q[i] <= DET_ZERO;
            end
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            det_q <= det_d;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first pending channel after last_grant, wrapping
    // ------------------------------------------------------------------
    always_comb begin
        int              idx;
        logic [CH_W-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        cand       = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(last_q) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            cand = CH_W'(idx);
            if (!pick_found && pending_q[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM and pending bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        last_d     = last_q;
        grant_mask = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d              = ARB_GRANT;
                    ch_d                 = pick_idx;
                    grant_mask[pick_idx] = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (evt.evt_ready) begin
                    state_d = ARB_IDLE;
                    last_d  = ch_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        // A fresh tick on the channel being granted re-arms it: set wins over clear.
        pending_d = (pending_q & ~grant_mask) | tick;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB_IDLE;
            pending_q <= '0;
            ch_q      <= '0;
            last_q    <= CH_W'(N_CH - 1);
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
        end
    end

    assign evt.evt_valid = (state_q == ARB_GRANT);
    assign evt.evt_ch    = ch_q;
    assign busy          = evt.evt_valid | (|pending_q);

`ifdef OVERRUN_FLAG_EN
    logic [N_CH-1:0] ovr_q;
    logic [N_CH-1:0] ovr_set;

    // An edge that lands on an already-pending channel (not the one leaving now) is lost.
    assign ovr_set = tick & pending_q & ~grant_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= (ovr_clr ? '0 : ovr_q) | ovr_set;
        end
    end

    assign ovr = ovr_q;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_edge_event_arbiter;

    localparam int N_CH = 4;
    localparam int CH_W = 2;

    logic            clk     = 1'b0;
    logic            reset_n = 1'b1;
    logic [N_CH-1:0] level   = '0;
    logic            busy;
`ifdef OVERRUN_FLAG_EN
    logic [N_CH-1:0] ovr;
    logic            ovr_clr = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    edge_event_arbiter_if #(.CH_W(CH_W)) evt ();

    edge_event_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (level),
        .evt     (evt.master),
        .busy    (busy)
`ifdef OVERRUN_FLAG_EN
        ,
        .ovr     (ovr),
        .ovr_clr (ovr_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: rising edge = level now 1 and previously 0;
    // requests wait in a pending set; one outstanding event at a time.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [N_CH-1:0] prev;
        logic [N_CH-1:0] tick;
        logic [N_CH-1:0] pending;
        logic [N_CH-1:0] ovr;
        logic            valid;
        logic [CH_W-1:0] ch;
        logic [CH_W-1:0] last;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r      = '0;
        r.last = CH_W'(N_CH - 1);
        return r;
    endfunction

    function automatic model_t model_step(model_t cur, logic [N_CH-1:0] lvl, logic rdy, logic clr);
        model_t          n;
        logic [N_CH-1:0] granted;
        n       = cur;
        granted = '0;
        if (!cur.valid) begin
            for (int k = 1; k <= N_CH; k++) begin
                int c;
                c = (int'(cur.last) + k) % N_CH;
                if (granted == '0 && cur.pending[c]) begin
                    granted[c] = 1'b1;
                    n.valid    = 1'b1;
                    n.ch       = CH_W'(c);
                end
            end
        end else if (rdy) begin
            n.valid = 1'b0;
            n.last  = cur.ch;
        end
        n.pending = (cur.pending & ~granted) | cur.tick;
        n.ovr     = (clr ? '0 : cur.ovr) | (cur.tick & cur.pending & ~granted);
        n.tick    = lvl & ~cur.prev;
        n.prev    = lvl;
        return n;
    endfunction

    logic clr_in;
`ifdef OVERRUN_FLAG_EN
    assign clr_in = ovr_clr;
`else
    assign clr_in = 1'b0;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= model_reset();
        else          m <= model_step(m, level, evt.evt_ready, clr_in);
    end

    always @(negedge clk) begin
        check("evt_valid", {31'd0, evt.evt_valid}, {31'd0, m.valid});
        check("evt_ch", 32'(evt.evt_ch), 32'(m.ch));
        check("busy", {31'd0, busy}, {31'd0, m.valid | (|m.pending)});
`ifdef OVERRUN_FLAG_EN
        check("ovr", 32'(ovr), 32'(m.ovr));
`endif
    end

    // ------------------------------------------------------------------
    // Handshake log (edge index at which valid&ready was taken)
    // ------------------------------------------------------------------
    typedef struct {
        int ch;
        int at;
    } ev_t;

    ev_t log_q[$];

    always @(posedge clk) begin
        if (reset_n && evt.evt_valid && evt.evt_ready) begin
            log_q.push_back('{ch: int'(evt.evt_ch), at: cyc + 1});
        end
        cyc <= cyc + 1;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n       = 1'b0;
        level         = '0;
        evt.evt_ready = 1'b0;
`ifdef OVERRUN_FLAG_EN
        ovr_clr       = 1'b0;
`endif
        tick_n(2);
        check("rst_valid", {31'd0, evt.evt_valid}, 32'd0);
        check("rst_ch", 32'(evt.evt_ch), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        log_q.delete();
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        while (!evt.evt_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, evt.evt_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n0;
        int n1;
        int n3;
        evt.evt_ready = 1'b0;
        #1 reset_n = 1'b0;

        // 1: single channel held high -> one event, fixed latency
        do_reset();
        evt.evt_ready = 1'b1;
        level = 4'b0010;
        t0 = cyc;
        tick_n(4);
        level = '0;
        tick_n(8);
        check("t1_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) begin
            check("t1_ch", 32'(log_q[0].ch), 32'd1);
            check("t1_latency", 32'(log_q[0].at - t0), 32'd4);
        end

        // 2: all channels at once -> 0,1,2,3 two cycles apart
        do_reset();
        evt.evt_ready = 1'b1;
        level = 4'b1111;
        tick_n(1);
        level = '0;
        tick_n(12);
        check("t2_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("t2_order", 32'(log_q[i].ch), 32'(i));
            if (i > 0) check("t2_gap", 32'(log_q[i].at - log_q[i-1].at), 32'd2);
        end
        check("t2_busy_end", {31'd0, busy}, 32'd0);

        // 3: stalled grant stays stable, then round-robin continues at ch0
        do_reset();
        level = 4'b0100;
        tick_n(1);
        level = '0;
        wait_valid(8, "t3_wait_valid");
        level = 4'b0001;
        tick_n(1);
        level = '0;
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", {31'd0, evt.evt_valid}, 32'd1);
            check("t3_hold_ch", 32'(evt.evt_ch), 32'd2);
            tick_n(1);
        end
        evt.evt_ready = 1'b1;
        tick_n(8);
        check("t3_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() >= 2) begin
            check("t3_first", 32'(log_q[0].ch), 32'd2);
            check("t3_second", 32'(log_q[1].ch), 32'd0);
        end

        // 4: ch0 and ch1 toggling continuously -> strict alternation
        do_reset();
        evt.evt_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            level = (k % 2 == 0) ? 4'b0011 : 4'b0000;
            tick_n(1);
        end
        level = '0;
        tick_n(10);
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].ch == 0) n0++;
            if (log_q[i].ch == 1) n1++;
            if (i > 0) check("t4_alternate", {31'd0, log_q[i].ch != log_q[i-1].ch}, 32'd1);
        end
        check("t4_ch0_served", {31'd0, n0 >= 4}, 32'd1);
        check("t4_ch1_served", {31'd0, n1 >= 4}, 32'd1);

        // 5: ch3 edges while already pending merge (and flag overrun if built in)
        do_reset();
        level = 4'b0001;
        tick_n(1);
        level = '0;
        wait_valid(8, "t5_wait_valid");
        level = 4'b1000;
        tick_n(1);
        level = '0;
        tick_n(2);
        level = 4'b1000;
        tick_n(1);
        level = '0;
        tick_n(3);
`ifdef OVERRUN_FLAG_EN
        check("t5_ovr_set", 32'(ovr), 32'h8);
        ovr_clr = 1'b1;
        tick_n(1);
        ovr_clr = 1'b0;
        check("t5_ovr_clr", 32'(ovr), 32'h0);
`endif
        evt.evt_ready = 1'b1;
        tick_n(10);
        n3 = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].ch == 3) n3++;
        end
        check("t5_ch3_events", 32'(n3), 32'd1);
        check("t5_total", 32'(log_q.size()), 32'd2);

        // 6: async reset during GRANT with requests pending
        do_reset();
        level = 4'b0111;
        tick_n(1);
        level = '0;
        wait_valid(8, "t6_wait_valid");
        tick_n(1);
        check("t6_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_valid_now", {31'd0, evt.evt_valid}, 32'd0);
        check("t6_busy_now", {31'd0, busy}, 32'd0);
        tick_n(2);
        reset_n = 1'b1;
        log_q.delete();
        evt.evt_ready = 1'b1;
        tick_n(12);
        check("t6_no_events", 32'(log_q.size()), 32'd0);

        // Randomized traffic, checked every cycle by the model
        do_reset();
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 2) == 0) level = N_CH'($urandom);
            evt.evt_ready = ($urandom_range(0, 3) != 0);
`ifdef OVERRUN_FLAG_EN
            ovr_clr = ($urandom_range(0, 15) == 0);
`endif
            tick_n(1);
        end
        level         = '0;
        evt.evt_ready = 1'b1;
`ifdef OVERRUN_FLAG_EN
        ovr_clr       = 1'b0;
`endif
        tick_n(20);
        check("rand_drained", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
